// File: rtl/aes_pkg.sv
// Shared AES definitions: block/round constants, key-schedule state encoding and
// small GF(2^8)/word helpers used by the key schedule.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W   = 128;
    localparam int unsigned AES128_ROUNDS = 10;

    typedef enum logic [0:0] {
        KE_IDLE = 1'b0,
        KE_RUN  = 1'b1
    } ke_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, 8-bit in to 8-bit out.
// Also used by the SubBytes stage.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 on-the-fly key schedule: accepts one cipher key and streams round keys
// 0..NUM_ROUNDS over a valid/ready handshake, deriving each key from the previous one.
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AES_BLOCK_W-1:0] key_in,
    input  logic                   vin,
    output logic                   ready_in,
    output logic [AES_BLOCK_W-1:0] round_key,
    output logic [3:0]             round_idx,
    output logic                   vout,
    input  logic                   rk_ready,
    output logic                   last
);

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

    ke_state_e              state_q, state_d;
    logic [AES_BLOCK_W-1:0] key_q;
    logic [3:0]             idx_q;
    logic [7:0]             rcon_q;

    logic                   at_last;
    logic                   xfer;
    logic                   load;
    logic                   advance;
    logic [31:0]            rot;
    logic [31:0]            sub;
    logic [31:0]            t;
    logic [31:0]            w0n, w1n, w2n, w3n;
    logic [AES_BLOCK_W-1:0] key_next;

    assign at_last = (idx_q == LAST_IDX);
    assign xfer    = vout && rk_ready;
    assign load    = (state_q == KE_IDLE) && vin;
    assign advance = xfer && !at_last;

    // next(): SubWord(RotWord(w3)) ^ rcon, then the chained word XORs.
    assign rot = rot_word(key_q[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (
            .din  (rot[8*i +: 8]),
            .dout (sub[8*i +: 8])
        );
    end

    assign t        = sub ^ {rcon_q, 24'h000000};
    assign w0n      = key_q[127:96] ^ t;
    assign w1n      = key_q[95:64]  ^ w0n;
    assign w2n      = key_q[63:32]  ^ w1n;
    assign w3n      = key_q[31:0]   ^ w2n;
    assign key_next = {w0n, w1n, w2n, w3n};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= KE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            KE_IDLE: if (vin) state_d = KE_RUN;
            KE_RUN:  if (xfer && at_last) state_d = KE_IDLE;
            default: state_d = KE_IDLE;
        endcase
    end

    always_comb begin
        ready_in  = (state_q == KE_IDLE);
        vout      = (state_q == KE_RUN);
        last      = vout && at_last;
        round_key = key_q;
        round_idx = idx_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q  <= '0;
            idx_q  <= '0;
            rcon_q <= 8'h01;
        end else if (load) begin
            key_q  <= key_in;
            idx_q  <= '0;
            rcon_q <= 8'h01;
        end else if (advance) begin
            key_q  <= key_next;
            idx_q  <= idx_q + 4'd1;
            rcon_q <= xtime(rcon_q);
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: expected round keys come from an independent
// GF(2^8)-inverse S-box model, pushed to a scoreboard and checked on each transfer.
module tb_aes_key_expand;

    localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK1_FIPS  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK4_FIPS  = 128'hef44a541a8525b7fb671253bdb0bad00;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK10_SEQ  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         vin;
    logic         ready_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         vout;
    logic         rk_ready;
    logic         last;

    logic [127:0] key_in4;
    logic         vin4;
    logic         ready_in4;
    logic [127:0] round_key4;
    logic [3:0]   round_idx4;
    logic         vout4;
    logic         rk_ready4;
    logic         last4;

    always #5 clk = ~clk;

    aes_key_expand #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .vin       (vin),
        .ready_in  (ready_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .vout      (vout),
        .rk_ready  (rk_ready),
        .last      (last)
    );

    aes_key_expand #(.NUM_ROUNDS(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in4),
        .vin       (vin4),
        .ready_in  (ready_in4),
        .round_key (round_key4),
        .round_idx (round_idx4),
        .vout      (vout4),
        .rk_ready  (rk_ready4),
        .last      (last4)
    );

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] mk  [0:10];
    logic [127:0] cap [0:15];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3 = k[31:0];
        logic [31:0] r  = {w3[23:0], w3[31:24]};
        logic [31:0] s  = {sbox_m[r[31:24]], sbox_m[r[23:16]], sbox_m[r[15:8]], sbox_m[r[7:0]]};
        logic [31:0] a, b, c, d;
        a = k[127:96] ^ s ^ {rc, 24'h0};
        b = k[95:64] ^ a;
        c = k[63:32] ^ b;
        d = k[31:0] ^ c;
        return {a, b, c, d};
    endfunction

    task automatic model_sched(input logic [127:0] k);
        logic [7:0] rc = 8'h01;
        mk[0] = k;
        for (int i = 1; i <= 10; i++) begin
            mk[i] = model_next(mk[i-1], rc);
            rc    = gmul(rc, 8'h02);
        end
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_schedule(input logic [127:0] k);
        model_sched(k);
        for (int i = 0; i <= 10; i++) begin
            sb.push_back('{idx: 4'(i), key: mk[i], last: (i == 10)});
        end
    endtask

    // One cycle: drive rk_ready, sample mid-cycle, score any transfer.
    task automatic cyc(input logic rkr);
        exp_t e;
        rk_ready = rkr;
        @(negedge clk);
        if (vout && rk_ready) begin
            cap[round_idx] = round_key;
            if (sb.size() == 0) begin
                chk("sb_underflow", 128'(sb.size()), 128'd1);
            end else begin
                e = sb.pop_front();
                chk("xfer_idx", 128'(round_idx), 128'(e.idx));
                chk("xfer_key", round_key, e.key);
                chk("xfer_last", 128'(last), 128'(e.last));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] k);
        vin    = 1'b1;
        key_in = k;
        @(negedge clk);
        chk("start_ready_in", 128'(ready_in), 128'd1);
        push_schedule(k);
        @(posedge clk);
        #1;
        vin = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            cyc(1'b1);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 128'(sb.size()), 128'd0);
    endtask

    initial begin
        int n;
        int n4;
        rst       = 1'b1;
        vin       = 1'b0;
        key_in    = '0;
        rk_ready  = 1'b1;
        vin4      = 1'b0;
        key_in4   = '0;
        rk_ready4 = 1'b1;
        build_sbox();
        #1;
        chk("rst_ready_in", 128'(ready_in), 128'd1);
        chk("rst_vout", 128'(vout), 128'd0);
        chk("rst_round_key", round_key, 128'd0);
        chk("rst_round_idx", 128'(round_idx), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_vout", 128'(vout), 128'd0);
        chk("idle_last", 128'(last), 128'd0);
        @(posedge clk);
        #1;

        // FIPS-197 A.1 at full throughput
        start(K_FIPS);
        drain(n);
        chk("a1_cycles", 128'(n), 128'd11);
        chk("a1_idx1", cap[1], RK1_FIPS);
        chk("a1_idx10", cap[10], RK10_FIPS);
        @(negedge clk);
        chk("a1_done_ready_in", 128'(ready_in), 128'd1);
        chk("a1_done_vout", 128'(vout), 128'd0);
        chk("a1_done_idx_hold", 128'(round_idx), 128'd10);
        chk("a1_done_key_hold", round_key, RK10_FIPS);
        @(posedge clk);
        #1;

        // Backpressure at idx 4
        start(K_FIPS);
        for (int i = 0; i < 4; i++) cyc(1'b1);
        for (int i = 0; i < 3; i++) begin
            rk_ready = 1'b0;
            @(negedge clk);
            chk("bp_key", round_key, RK4_FIPS);
            chk("bp_idx", 128'(round_idx), 128'd4);
            chk("bp_vout", 128'(vout), 128'd1);
            @(posedge clk);
            #1;
        end
        drain(n);
        chk("bp_idx10", cap[10], RK10_FIPS);

        // vin during RUN is ignored
        start(K_FIPS);
        cyc(1'b1);
        chk("run_ready_in", 128'(ready_in), 128'd0);
        vin    = 1'b1;
        key_in = K_SEQ;
        cyc(1'b1);
        vin = 1'b0;
        drain(n);
        chk("ign_idx10", cap[10], RK10_FIPS);
        start(K_SEQ);
        drain(n);
        chk("seq_idx10", cap[10], RK10_SEQ);

        // Asynchronous reset at idx 6
        start(K_FIPS);
        for (int i = 0; i < 6; i++) cyc(1'b1);
        chk("pre_rst_idx", 128'(round_idx), 128'd6);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vout", 128'(vout), 128'd0);
        chk("arst_ready_in", 128'(ready_in), 128'd1);
        chk("arst_round_idx", 128'(round_idx), 128'd0);
        chk("arst_round_key", round_key, 128'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_vout", 128'(vout), 128'd0);
        @(posedge clk);
        #1;
        start(K_SEQ);
        drain(n);
        chk("post_rst_cycles", 128'(n), 128'd11);

        // Back-to-back: new vin in the first IDLE cycle after last
        start(K_FIPS);
        drain(n);
        start(K_SEQ);
        chk("b2b_vout", 128'(vout), 128'd1);
        drain(n);
        chk("b2b_idx0", cap[0], K_SEQ);
        chk("b2b_idx10", cap[10], RK10_SEQ);

        // NUM_ROUNDS = 4 instance
        model_sched(K_FIPS);
        vin4    = 1'b1;
        key_in4 = K_FIPS;
        @(posedge clk);
        #1;
        vin4 = 1'b0;
        n4   = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (vout4) begin
                chk("r4_idx", 128'(round_idx4), 128'(n4));
                chk("r4_key", round_key4, mk[(n4 > 10) ? 10 : n4]);
                chk("r4_last", 128'(last4), 128'(n4 == 4));
                n4++;
            end
            @(posedge clk);
            #1;
        end
        chk("r4_xfers", 128'(n4), 128'd5);
        chk("r4_ready_in", 128'(ready_in4), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
